multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath.
- Steps one shared ALU, one unified memory port and the register file through fetch, decode, execute, memory and write-back phases.
- Drives the 3-bit ALUOp consumed by the ALU controller, using the same encoding: 0 R-type, 1 addi, 2 slti, 3 beq/subtract, 4 add for lw/sw/PC arithmetic.
- Sits beside the ALU controller, between the instruction register and the datapath muxes and enables.

---
 rtl/multicycle_pkg.sv | 69 ++++++
 rtl/multicycle_ctrl_if.sv | 51 +++++
 rtl/multicycle_ctrl_decode.sv | 103 ++++++++++
 rtl/multicycle_ctrl.sv | 88 ++++++++
 tb/tb_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
// Shared constants and types for the multi-cycle MIPS control FSM.
// Optional memory wait states are enabled by MULTICYCLE_MEM_WAIT_EN.
package multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FUNCT_JR = 6'd8;

  localparam logic [2:0] ALU_RTYPE = 3'd0;
  localparam logic [2:0] ALU_ADDI  = 3'd1;
  localparam logic [2:0] ALU_SLTI  = 3'd2;
  localparam logic [2:0] ALU_SUB   = 3'd3;
  localparam logic [2:0] ALU_ADD   = 3'd4;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_RA  = 2'd2;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MDR  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic [1:0] SRCB_RT = 2'd0;
  localparam logic [1:0] SRCB_4  = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR = 2'd3;
  localparam logic [1:0] PC_ALU  = 2'd0;
  localparam logic [1:0] PC_OUT  = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;
  localparam logic [1:0] PC_RS   = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the FSM (master) and the datapath (slave).
// mem_ready_i exists only with MULTICYCLE_MEM_WAIT_EN.
interface multicycle_ctrl_if #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
);
  logic [OP_W-1:0] instr_op_i;
  logic [OP_W-1:0] funct_i;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic            mem_ready_i;
`endif
  logic            PCWrite_o;
  logic            PCWriteCond_o;
  logic            IorD_o;
  logic            MemRead_o;
  logic            MemWrite_o;
  logic            IRWrite_o;
  logic [1:0]      RegDst_o;
  logic [1:0]      MemtoReg_o;
  logic            RegWrite_o;
  logic            ALUSrcA_o;
  logic [1:0]      ALUSrcB_o;
  logic [2:0]      ALUOp_o;
  logic [1:0]      PCSource_o;
  logic [ST_W-1:0] state_o;
  logic            illegal_o;

  modport master (
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  mem_ready_i,
`endif
    input  instr_op_i, funct_i,
    output PCWrite_o, PCWriteCond_o, IorD_o,
    output MemRead_o, MemWrite_o, IRWrite_o,
    output RegDst_o, MemtoReg_o, RegWrite_o,
    output ALUSrcA_o, ALUSrcB_o, ALUOp_o,
    output PCSource_o, state_o, illegal_o
  );

  modport slave (
`ifdef MULTICYCLE_MEM_WAIT_EN
    output mem_ready_i,
`endif
    output instr_op_i, funct_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o,
    input  MemRead_o, MemWrite_o, IRWrite_o,
    input  RegDst_o, MemtoReg_o, RegWrite_o,
    input  ALUSrcA_o, ALUSrcB_o, ALUOp_o,
    input  PCSource_o, state_o, illegal_o
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// State-to-control-word decoder for the multi-cycle control FSM.
// With MULTICYCLE_MEM_WAIT_EN, fetch-side PC/IR loads wait on memory.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_e          state_i,
  input  logic [OP_W-1:0] op_i,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic            mem_ready_i,
`endif
  output ctrl_t           cw_o
);

  logic fetch_go;
`ifdef MULTICYCLE_MEM_WAIT_EN
  assign fetch_go = mem_ready_i;
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    cw_o = '0;
    unique case (state_i)
      S_FETCH: begin
        cw_o.mem_read  = 1'b1;
        cw_o.ir_write  = fetch_go;
        cw_o.alu_src_b = SRCB_4;
        cw_o.alu_op    = ALU_ADD;
        cw_o.pc_write  = fetch_go;
        cw_o.pc_source = PC_ALU;
      end
      S_DECODE: begin
        cw_o.alu_src_b = SRCB_BR;
        cw_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        cw_o.mem_read = 1'b1;
        cw_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.reg_dst    = DST_RT;
        cw_o.mem_to_reg = WB_MDR;
      end
      S_MEM_WR: begin
        cw_o.mem_write = 1'b1;
        cw_o.iord      = 1'b1;
      end
      S_R_EXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_RT;
        cw_o.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.reg_dst    = DST_RD;
        cw_o.mem_to_reg = WB_ALU;
      end
      S_BRANCH: begin
        cw_o.alu_src_a     = 1'b1;
        cw_o.alu_src_b     = SRCB_RT;
        cw_o.alu_op        = ALU_SUB;
        cw_o.pc_write_cond = 1'b1;
        cw_o.pc_source     = PC_OUT;
      end
      S_JUMP: begin
        cw_o.pc_write  = 1'b1;
        cw_o.pc_source = PC_JMP;
      end
      S_I_EXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = (op_i == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
      end
      S_I_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.reg_dst    = DST_RT;
        cw_o.mem_to_reg = WB_ALU;
      end
      // PC already holds PC+4, so it is the link value.
      S_JAL: begin
        cw_o.reg_write  = 1'b1;
        cw_o.reg_dst    = DST_RA;
        cw_o.mem_to_reg = WB_PC;
        cw_o.pc_write   = 1'b1;
        cw_o.pc_source  = PC_JMP;
      end
      S_JR: begin
        cw_o.pc_write  = 1'b1;
        cw_o.pc_source = PC_RS;
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Optional memory wait states: define MULTICYCLE_MEM_WAIT_EN.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  multicycle_ctrl_if.master  bus
);

  state_e          state_q, state_d;
  logic            illegal;
  logic            mem_go;
  ctrl_t           cw, cw_g;
  logic [OP_W-1:0] op, fn;

  assign op = bus.instr_op_i;
  assign fn = bus.funct_i;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_go = bus.mem_ready_i;
`else
  assign mem_go = 1'b1;
`endif

  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    unique case (state_q)
      S_FETCH:  state_d = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_RTYPE) && (fn == FUNCT_JR): state_d = S_JR;
          (op == OP_RTYPE) && (fn != FUNCT_JR): state_d = S_R_EXEC;
          (op == OP_LW) || (op == OP_SW):       state_d = S_MEM_ADDR;
          (op == OP_BEQ):                       state_d = S_BRANCH;
          (op == OP_ADDI) || (op == OP_SLTI):   state_d = S_I_EXEC;
          (op == OP_J):                         state_d = S_JUMP;
          (op == OP_JAL):                       state_d = S_JAL;
          default:                              illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_go ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = mem_go ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  multicycle_ctrl_decode #(.OP_W(OP_W)) u_decode (
    .state_i     (state_q),
    .op_i        (op),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready_i (bus.mem_ready_i),
`endif
    .cw_o        (cw)
  );

  // Reset silences every strobe, aborting any in-flight instruction.
  assign cw_g = rst_i ? '0 : cw;

  assign bus.PCWrite_o     = cw_g.pc_write;
  assign bus.PCWriteCond_o = cw_g.pc_write_cond;
  assign bus.IorD_o        = cw_g.iord;
  assign bus.MemRead_o     = cw_g.mem_read;
  assign bus.MemWrite_o    = cw_g.mem_write;
  assign bus.IRWrite_o     = cw_g.ir_write;
  assign bus.RegDst_o      = cw_g.reg_dst;
  assign bus.MemtoReg_o    = cw_g.mem_to_reg;
  assign bus.RegWrite_o    = cw_g.reg_write;
  assign bus.ALUSrcA_o     = cw_g.alu_src_a;
  assign bus.ALUSrcB_o     = cw_g.alu_src_b;
  assign bus.ALUOp_o       = cw_g.alu_op;
  assign bus.PCSource_o    = cw_g.pc_source;
  assign bus.state_o       = rst_i ? '0 : ST_W'(state_q);
  assign bus.illegal_o     = illegal && !rst_i;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level model
// plus literal latency/strobe pins; covers MULTICYCLE_MEM_WAIT_EN too.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic [3:0] st;
    logic       ill;
  } cw_t;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OP_W(6), .ST_W(4)) bus ();

  multicycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  cw_t   expq[$];
  cw_t   obs[$];
  int    total = 0;
  int    bad = 0;
  string tag = "init";

  function automatic cw_t act();
    cw_t a;
    a.pcw   = bus.PCWrite_o;
    a.pcwc  = bus.PCWriteCond_o;
    a.iord  = bus.IorD_o;
    a.mrd   = bus.MemRead_o;
    a.mwr   = bus.MemWrite_o;
    a.irw   = bus.IRWrite_o;
    a.rdst  = bus.RegDst_o;
    a.m2r   = bus.MemtoReg_o;
    a.rw    = bus.RegWrite_o;
    a.srca  = bus.ALUSrcA_o;
    a.srcb  = bus.ALUSrcB_o;
    a.aluop = bus.ALUOp_o;
    a.pcsrc = bus.PCSource_o;
    a.st    = bus.state_o;
    a.ill   = bus.illegal_o;
    return a;
  endfunction

  // Control word the datapath needs during one step of an instruction.
  function automatic cw_t spec_word(int st, logic [5:0] op);
    cw_t w = '0;
    w.st = st[3:0];
    case (st)
      0:  begin w.mrd = 1; w.irw = 1; w.srcb = 1; w.aluop = 4; w.pcw = 1; end
      1:  begin w.srcb = 3; w.aluop = 4; end
      2:  begin w.srca = 1; w.srcb = 2; w.aluop = 4; end
      3:  begin w.mrd = 1; w.iord = 1; end
      4:  begin w.rw = 1; w.m2r = 1; end
      5:  begin w.mwr = 1; w.iord = 1; end
      6:  begin w.srca = 1; w.aluop = 0; end
      7:  begin w.rw = 1; w.rdst = 1; end
      8:  begin w.srca = 1; w.aluop = 3; w.pcwc = 1; w.pcsrc = 1; end
      9:  begin w.pcw = 1; w.pcsrc = 2; end
      10: begin w.srca = 1; w.srcb = 2; w.aluop = (op == 6'd10) ? 3'd2 : 3'd1; end
      11: begin w.rw = 1; end
      12: begin w.rw = 1; w.rdst = 2; w.m2r = 2; w.pcw = 1; w.pcsrc = 2; end
      13: begin w.pcw = 1; w.pcsrc = 3; end
      default: w = '0;
    endcase
    return w;
  endfunction

  // Step list of one instruction, derived from its class.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn);
    int  path[$];
    bit  ill = 0;
    cw_t w;
    path = {0, 1};
    case (op)
      6'd0:         if (fn == 6'd8) path.push_back(13);
                    else begin path.push_back(6); path.push_back(7); end
      6'd35:        begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'd43:        begin path.push_back(2); path.push_back(5); end
      6'd4:         path.push_back(8);
      6'd8, 6'd10:  begin path.push_back(10); path.push_back(11); end
      6'd2:         path.push_back(9);
      6'd3:         path.push_back(12);
      default:      ill = 1;
    endcase
    foreach (path[i]) begin
      w = spec_word(path[i], op);
      if (path[i] == 1) w.ill = ill;
      expq.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    cw_t e, a;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      a = act();
      obs.push_back(a);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s cyc%0d got=%h want=%h", tag, obs.size() - 1, a, e);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(posedge clk);
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=%0d want=0 pending", tag, expq.size());
      expq.delete();
    end
    #1;
  endtask

  task automatic run(input string nm, input logic [5:0] op,
                     input logic [5:0] fn, input int lat);
    tag = nm;
    bus.instr_op_i = op;
    bus.funct_i    = fn;
    obs.delete();
    push_instr(op, fn);
    drain();
    chk({nm, "_lat"}, obs.size(), lat);
  endtask

  initial begin
    rst_i = 1'b1;
    bus.instr_op_i = 6'd0;
    bus.funct_i    = 6'd0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    bus.mem_ready_i = 1'b1;
`endif
    tag = "reset";
    expq.push_back('0);
    expq.push_back('0);
    drain();
    rst_i = 1'b0;

    run("lw", 6'd35, 6'd0, 5);
    chk("lw_rw5", int'(obs[4].rw), 1);
    chk("lw_m2r5", int'(obs[4].m2r), 1);
    chk("lw_iord4", int'(obs[3].iord), 1);
    run("sw", 6'd43, 6'd0, 4);
    run("add", 6'd0, 6'd32, 4);
    chk("add_aluop3", int'(obs[2].aluop), 0);
    chk("add_rdst4", int'(obs[3].rdst), 1);
    run("beq", 6'd4, 6'd0, 3);
    chk("beq_pcwc3", int'(obs[2].pcwc), 1);
    run("j", 6'd2, 6'd0, 3);
    run("jal", 6'd3, 6'd0, 3);
    chk("jal_rdst", int'(obs[2].rdst), 2);
    run("jr", 6'd0, 6'd8, 3);
    chk("jr_pcsrc", int'(obs[2].pcsrc), 3);
    run("addi", 6'd8, 6'd0, 4);
    run("slti", 6'd10, 6'd0, 4);
    chk("slti_aluop", int'(obs[2].aluop), 2);
    run("ill", 6'd63, 6'd0, 2);
    chk("ill_dec", int'(obs[1].ill), 1);
    chk("ill_fetch", int'(obs[0].ill), 0);

    // Abort an R-type in its execute step with a 2-cycle reset.
    tag = "rst_mid";
    bus.instr_op_i = 6'd0;
    bus.funct_i    = 6'd32;
    obs.delete();
    expq.push_back(spec_word(0, 6'd0));
    expq.push_back(spec_word(1, 6'd0));
    drain();
    chk("rst_mid_in_rexec", int'(bus.state_o), 6);
    rst_i = 1'b1;
    expq.push_back('0);
    expq.push_back('0);
    drain();
    rst_i = 1'b0;
    run("after_rst", 6'd0, 6'd32, 4);
    chk("after_rst_mrd", int'(obs[0].mrd), 1);
    chk("after_rst_irw", int'(obs[0].irw), 1);
    chk("after_rst_pcw", int'(obs[0].pcw), 1);

`ifdef MULTICYCLE_MEM_WAIT_EN
    begin
      cw_t hold;
      int  pulses;
      tag = "wait";
      bus.instr_op_i = 6'd4;
      bus.funct_i    = 6'd0;
      obs.delete();
      hold = spec_word(0, 6'd4);
      hold.pcw = 1'b0;
      hold.irw = 1'b0;
      bus.mem_ready_i = 1'b0;
      repeat (3) expq.push_back(hold);
      push_instr(6'd4, 6'd0);
      repeat (3) @(posedge clk);
      #1 bus.mem_ready_i = 1'b1;
      drain();
      chk("wait_lat", obs.size(), 6);
      pulses = 0;
      foreach (obs[i]) if (obs[i].st == 4'd0 && obs[i].pcw) pulses++;
      chk("wait_pcw_pulses", pulses, 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
